// File: rtl/pong_pixel_engine.sv
// pong_pixel_engine: Pong game state and pixel painter fed by hvsync_generator.
// Paddle/ball/score advance once per frame (one state per clock, started at the
// frame tick in blanking). Colour and syncs are registered together so they
// leave on the same clock.
// Direction encoding on the debug outputs: dir_x 1 = right, dir_y 1 = down.
module pong_pixel_engine #(
  parameter int PADDLE_X    = 16,
  parameter int PADDLE_H    = 64,
  parameter int PADDLE_STEP = 4,
  parameter int BALL_SPEED  = 2,
  parameter int WALL        = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [9:0] counter_x,
  input  logic [8:0] counter_y,
  input  logic       in_display_area,
  input  logic       h_sync_in,
  input  logic       v_sync_in,
  input  logic       btn_up,
  input  logic       btn_down,
  output logic       vga_r,
  output logic       vga_g,
  output logic       vga_b,
  output logic       vga_h_sync,
  output logic       vga_v_sync,
  output logic [7:0] miss_count,
  output logic [1:0] o_dbg_state,
  output logic [8:0] o_dbg_paddle_y,
  output logic [9:0] o_dbg_ball_x,
  output logic [8:0] o_dbg_ball_y,
  output logic       o_dbg_dir_x,
  output logic       o_dbg_dir_y
);

  // All geometry is compared in 11 bits so sums like y+8 or x+SPEED never wrap.
  localparam logic [10:0] L_SCR_H   = 11'd480;
  localparam logic [10:0] L_BALL    = 11'd8;
  localparam logic [10:0] L_PX      = 11'(PADDLE_X);
  localparam logic [10:0] L_FACE    = 11'(PADDLE_X + 8);
  localparam logic [10:0] L_PH      = 11'(PADDLE_H);
  localparam logic [10:0] L_STEP    = 11'(PADDLE_STEP);
  localparam logic [10:0] L_SPD     = 11'(BALL_SPEED);
  localparam logic [10:0] L_WALL    = 11'(WALL);
  localparam logic [10:0] L_X_MAX   = 11'(640 - WALL - 8);
  localparam logic [10:0] L_Y_MAX   = 11'(480 - WALL - 8);
  localparam logic [10:0] L_Y_TOP   = 11'(WALL + BALL_SPEED);
  localparam logic [10:0] L_WALL_B  = 11'(480 - WALL);
  localparam logic [10:0] L_WALL_R  = 11'(640 - WALL);
  localparam logic [8:0]  PY_MAX    = 9'(480 - PADDLE_H);
  localparam logic [8:0]  PY_RST    = 9'((480 - PADDLE_H) / 2);
  localparam logic [9:0]  BX_RST    = 10'((640 - 8) / 2);
  localparam logic [8:0]  BY_RST    = 9'((480 - 8) / 2);

  typedef enum logic [1:0] {
    S_WAIT   = 2'd0,
    S_PADDLE = 2'd1,
    S_BALL_X = 2'd2,
    S_BALL_Y = 2'd3
  } state_t;

  state_t      r_state, w_state_nxt;
  logic [1:0]  r_up_sync, r_dn_sync;
  logic [8:0]  r_paddle_y, w_paddle_y_nxt;
  logic [9:0]  r_ball_x, w_ball_x_nxt;
  logic [8:0]  r_ball_y, w_ball_y_nxt;
  logic        r_dir_x, w_dir_x_nxt;
  logic        r_dir_y, w_dir_y_nxt;
  logic [7:0]  r_miss_count, w_miss_nxt;

  logic [10:0] w_py, w_bx, w_by, w_cx, w_cy;
  logic        w_up, w_dn, w_frame_tick, w_face_cross, w_overlap;
  logic        w_on_ball, w_on_paddle, w_on_wall;

  assign w_py = {2'b00, r_paddle_y};
  assign w_bx = {1'b0, r_ball_x};
  assign w_by = {2'b00, r_ball_y};
  assign w_cx = {1'b0, counter_x};
  assign w_cy = {2'b00, counter_y};

  // Pressing both buttons at once means "hold".
  assign w_up = r_up_sync[1] & ~r_dn_sync[1];
  assign w_dn = r_dn_sync[1] & ~r_up_sync[1];

  assign w_frame_tick = (counter_x == 10'd767) && (counter_y == 9'd479) && (r_state == S_WAIT);

  // Ball steps past the paddle face this frame (ball_x - SPEED < face, without underflow).
  assign w_face_cross = (w_bx >= L_FACE) && (w_bx < L_FACE + L_SPD);
  // Vertical overlap with the paddle position written one clock earlier.
  assign w_overlap = (w_by + L_BALL > w_py) && (w_by < w_py + L_PH);

  assign w_on_ball   = (w_cx >= w_bx) && (w_cx < w_bx + L_BALL) &&
                       (w_cy >= w_by) && (w_cy < w_by + L_BALL);
  assign w_on_paddle = (w_cx >= L_PX) && (w_cx < L_PX + 11'd8) &&
                       (w_cy >= w_py) && (w_cy < w_py + L_PH);
  assign w_on_wall   = (w_cy < L_WALL) || (w_cy >= L_WALL_B) || (w_cx >= L_WALL_R);

  // Two-flop synchronisers for the asynchronous buttons.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_up_sync <= 2'b00;
      r_dn_sync <= 2'b00;
    end else begin
      r_up_sync <= {r_up_sync[0], btn_up};
      r_dn_sync <= {r_dn_sync[0], btn_down};
    end
  end

  // FSM state and game state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= S_WAIT;
      r_paddle_y   <= PY_RST;
      r_ball_x     <= BX_RST;
      r_ball_y     <= BY_RST;
      r_dir_x      <= 1'b1;
      r_dir_y      <= 1'b1;
      r_miss_count <= 8'd0;
    end else begin
      r_state      <= w_state_nxt;
      r_paddle_y   <= w_paddle_y_nxt;
      r_ball_x     <= w_ball_x_nxt;
      r_ball_y     <= w_ball_y_nxt;
      r_dir_x      <= w_dir_x_nxt;
      r_dir_y      <= w_dir_y_nxt;
      r_miss_count <= w_miss_nxt;
    end
  end

  // Next-state and per-frame update: paddle, then ball x, then ball y (skipped on a miss).
  always_comb begin
    w_state_nxt    = r_state;
    w_paddle_y_nxt = r_paddle_y;
    w_ball_x_nxt   = r_ball_x;
    w_ball_y_nxt   = r_ball_y;
    w_dir_x_nxt    = r_dir_x;
    w_dir_y_nxt    = r_dir_y;
    w_miss_nxt     = r_miss_count;
    case (r_state)
      S_WAIT: begin
        if (w_frame_tick) w_state_nxt = S_PADDLE;
      end
      S_PADDLE: begin
        w_state_nxt = S_BALL_X;
        if (w_up) begin
          w_paddle_y_nxt = (w_py >= L_STEP) ? 9'(w_py - L_STEP) : 9'd0;
        end else if (w_dn) begin
          w_paddle_y_nxt = (w_py + L_PH + L_STEP <= L_SCR_H) ? 9'(w_py + L_STEP) : PY_MAX;
        end
      end
      S_BALL_X: begin
        w_state_nxt = S_BALL_Y;
        if (!r_dir_x) begin
          if (w_face_cross && w_overlap) begin
            w_ball_x_nxt = 10'(L_FACE);
            w_dir_x_nxt  = 1'b1;
          end else if (w_bx < L_SPD) begin
            w_ball_x_nxt = BX_RST;
            w_ball_y_nxt = BY_RST;
            w_dir_x_nxt  = 1'b1;
            w_miss_nxt   = (r_miss_count == 8'hFF) ? r_miss_count : r_miss_count + 8'd1;
            w_state_nxt  = S_WAIT;
          end else begin
            w_ball_x_nxt = 10'(w_bx - L_SPD);
          end
        end else if (w_bx + L_SPD >= L_X_MAX) begin
          w_ball_x_nxt = 10'(L_X_MAX);
          w_dir_x_nxt  = 1'b0;
        end else begin
          w_ball_x_nxt = 10'(w_bx + L_SPD);
        end
      end
      S_BALL_Y: begin
        w_state_nxt = S_WAIT;
        if (!r_dir_y) begin
          if (w_by < L_Y_TOP) begin
            w_ball_y_nxt = 9'(L_WALL);
            w_dir_y_nxt  = 1'b1;
          end else begin
            w_ball_y_nxt = 9'(w_by - L_SPD);
          end
        end else if (w_by + L_SPD > L_Y_MAX) begin
          w_ball_y_nxt = 9'(L_Y_MAX);
          w_dir_y_nxt  = 1'b0;
        end else begin
          w_ball_y_nxt = 9'(w_by + L_SPD);
        end
      end
      default: w_state_nxt = S_WAIT;
    endcase
  end

  // Pixel painter: colour from the current counters, syncs delayed to stay aligned.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      {vga_r, vga_g, vga_b} <= 3'b000;
      vga_h_sync            <= 1'b1;
      vga_v_sync            <= 1'b1;
    end else begin
      vga_h_sync <= h_sync_in;
      vga_v_sync <= v_sync_in;
      if (!in_display_area)  {vga_r, vga_g, vga_b} <= 3'b000;
      else if (w_on_ball)    {vga_r, vga_g, vga_b} <= 3'b100;
      else if (w_on_paddle)  {vga_r, vga_g, vga_b} <= 3'b010;
      else if (w_on_wall)    {vga_r, vga_g, vga_b} <= 3'b111;
      else                   {vga_r, vga_g, vga_b} <= 3'b000;
    end
  end

  assign miss_count     = r_miss_count;
  assign o_dbg_state    = r_state;
  assign o_dbg_paddle_y = r_paddle_y;
  assign o_dbg_ball_x   = r_ball_x;
  assign o_dbg_ball_y   = r_ball_y;
  assign o_dbg_dir_x    = r_dir_x;
  assign o_dbg_dir_y    = r_dir_y;

endmodule

// File: tb/tb_pong_pixel_engine.sv
// Bench for pong_pixel_engine: drives the raster counters directly (a "frame" is a
// few paint cycles, the tick pixel and three blanking clocks), keeps a game model
// in plain integer arithmetic and checks every output cycle against it.
module tb_pong_pixel_engine;
  localparam int W = 44;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [9:0] counter_x = '0;
  logic [8:0] counter_y = '0;
  logic       in_display_area = 1'b0;
  logic       h_sync_in = 1'b1;
  logic       v_sync_in = 1'b1;
  logic       btn_up = 1'b0;
  logic       btn_down = 1'b0;
  logic       vga_r, vga_g, vga_b, vga_h_sync, vga_v_sync;
  logic [7:0] miss_count;
  logic [1:0] o_dbg_state;
  logic [8:0] o_dbg_paddle_y;
  logic [9:0] o_dbg_ball_x;
  logic [8:0] o_dbg_ball_y;
  logic       o_dbg_dir_x, o_dbg_dir_y;

  pong_pixel_engine dut (
    .clk(clk), .rst_n(rst_n), .counter_x(counter_x), .counter_y(counter_y),
    .in_display_area(in_display_area), .h_sync_in(h_sync_in), .v_sync_in(v_sync_in),
    .btn_up(btn_up), .btn_down(btn_down),
    .vga_r(vga_r), .vga_g(vga_g), .vga_b(vga_b),
    .vga_h_sync(vga_h_sync), .vga_v_sync(vga_v_sync), .miss_count(miss_count),
    .o_dbg_state(o_dbg_state), .o_dbg_paddle_y(o_dbg_paddle_y),
    .o_dbg_ball_x(o_dbg_ball_x), .o_dbg_ball_y(o_dbg_ball_y),
    .o_dbg_dir_x(o_dbg_dir_x), .o_dbg_dir_y(o_dbg_dir_y)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- counters and scoreboard ----------------
  int n_checks = 0;
  int n_pass = 0;
  logic [W-1:0] exp_q[$];
  bit st_valid = 1'b1;

  task automatic check(input string name, input int got, input int exp);
    n_checks++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
  endtask

  // ---------------- behavioural model ----------------
  int m_py, m_bx, m_by, m_dx, m_dy, m_miss, m_miss_events;

  function automatic void model_reset();
    m_py = 208; m_bx = 316; m_by = 236; m_dx = 1; m_dy = 1; m_miss = 0;
  endfunction

  // One whole frame of game rules, applied at once.
  function automatic void model_frame(input bit up, input bit dn);
    bit missed;
    missed = 1'b0;
    if (up && !dn)      m_py = (m_py >= 4) ? m_py - 4 : 0;
    else if (dn && !up) m_py = (m_py + 64 + 4 <= 480) ? m_py + 4 : 416;
    if (m_dx == 0) begin
      if (m_bx >= 24 && m_bx - 2 < 24 && m_by + 8 > m_py && m_by < m_py + 64) begin
        m_bx = 24; m_dx = 1;
      end else if (m_bx < 2) begin
        m_bx = 316; m_by = 236; m_dx = 1;
        if (m_miss < 255) m_miss++;
        m_miss_events++;
        missed = 1'b1;
      end else m_bx -= 2;
    end else if (m_bx + 2 >= 624) begin
      m_bx = 624; m_dx = 0;
    end else m_bx += 2;
    if (!missed) begin
      if (m_dy == 0) begin
        if (m_by < 10) begin m_by = 8; m_dy = 1; end
        else m_by -= 2;
      end else if (m_by + 2 > 464) begin
        m_by = 464; m_dy = 0;
      end else m_by += 2;
    end
  endfunction

  function automatic logic [2:0] model_pixel(input int x, input int y, input bit de);
    if (!de) return 3'b000;
    if (x >= m_bx && x < m_bx + 8 && y >= m_by && y < m_by + 8) return 3'b100;
    if (x >= 16 && x < 24 && y >= m_py && y < m_py + 64) return 3'b010;
    if (y < 8 || y >= 472 || x >= 632) return 3'b111;
    return 3'b000;
  endfunction

  // ---------------- compare process ----------------
  logic [W-1:0] cmp_e;
  logic       e_valid, e_hs, e_vs, e_dx, e_dy;
  logic [2:0] e_rgb;
  logic [7:0] e_miss;
  logic [8:0] e_py, e_by;
  logic [9:0] e_bx;

  always @(posedge clk) begin
    #1;
    if (exp_q.size() > 0) begin
      cmp_e = exp_q.pop_front();
      {e_valid, e_rgb, e_hs, e_vs, e_miss, e_py, e_bx, e_by, e_dx, e_dy} = cmp_e;
      check("rgb_syncs", int'({vga_r, vga_g, vga_b, vga_h_sync, vga_v_sync}),
            int'({e_rgb, e_hs, e_vs}));
      if (e_valid) begin
        check("miss_count", int'(miss_count), int'(e_miss));
        check("paddle_y", int'(o_dbg_paddle_y), int'(e_py));
        check("ball_x", int'(o_dbg_ball_x), int'(e_bx));
        check("ball_y", int'(o_dbg_ball_y), int'(e_by));
        check("dirs", int'({o_dbg_dir_x, o_dbg_dir_y}), int'({e_dx, e_dy}));
        check("idle_state", int'(o_dbg_state), 0);
      end
    end
  end

  // ---------------- driver tasks ----------------
  function automatic bit rb();
    return 1'($urandom_range(0, 1));
  endfunction

  task automatic cycle(input int x, input int y, input bit de, input bit hs, input bit vs);
    @(negedge clk);
    counter_x = 10'(x);
    counter_y = 9'(y);
    in_display_area = de;
    h_sync_in = hs;
    v_sync_in = vs;
    exp_q.push_back({st_valid, model_pixel(x, y, de), hs, vs, 8'(m_miss), 9'(m_py),
                     10'(m_bx), 9'(m_by), 1'(m_dx), 1'(m_dy)});
  endtask

  task automatic settle();
    @(posedge clk);
    #2;
  endtask

  task automatic paint_random();
    int sel, x, y;
    sel = int'($urandom_range(0, 3));
    if (sel < 2) begin
      x = m_bx + int'($urandom_range(0, 9)) - 1;
      y = m_by + int'($urandom_range(0, 9)) - 1;
    end else if (sel == 2) begin
      x = int'($urandom_range(12, 27));
      y = m_py + int'($urandom_range(0, 67)) - 2;
    end else begin
      x = int'($urandom_range(0, 767));
      y = int'($urandom_range(0, 511));
    end
    if (x < 0) x = 0;
    if (y < 0) y = 0;
    if (x > 767) x = 767;
    if (y > 511) y = 511;
    if (x == 767 && y == 479) y = 478;
    cycle(x, y, $urandom_range(0, 7) != 0, rb(), rb());
  endtask

  task automatic frame(input bit up, input bit dn, input int n_paint);
    btn_up = up;
    btn_down = dn;
    st_valid = 1'b1;
    for (int i = 0; i < n_paint; i++) paint_random();
    st_valid = 1'b0;
    cycle(767, 479, 1'b0, rb(), rb());
    repeat (3) cycle(640 + int'($urandom_range(0, 126)), int'($urandom_range(0, 511)), 1'b0, rb(), rb());
    model_frame(up, dn);
    st_valid = 1'b1;
  endtask

  task automatic pin_reset_values(input string tag);
    check({tag, "_rgb"}, int'({vga_r, vga_g, vga_b}), 0);
    check({tag, "_syncs"}, int'({vga_h_sync, vga_v_sync}), 3);
    check({tag, "_paddle_y"}, int'(o_dbg_paddle_y), 208);
    check({tag, "_ball_x"}, int'(o_dbg_ball_x), 316);
    check({tag, "_ball_y"}, int'(o_dbg_ball_y), 236);
    check({tag, "_dirs"}, int'({o_dbg_dir_x, o_dbg_dir_y}), 3);
    check({tag, "_miss"}, int'(miss_count), 0);
    check({tag, "_state"}, int'(o_dbg_state), 0);
  endtask

  task automatic do_reset(input string tag);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    exp_q.delete();
    #1;
    pin_reset_values(tag);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    st_valid = 1'b1;
  endtask

  // ---------------- main sequence ----------------
  int n_fr, ev0;
  bit r_up, r_dn;

  initial begin
    model_reset();
    m_miss_events = 0;
    repeat (3) @(posedge clk);
    #2;
    pin_reset_values("por");
    @(negedge clk);
    rst_n = 1'b1;

    // painting priorities, boundaries and sync delay
    cycle(320, 0, 1'b1, 1'b1, 1'b1);   settle(); check("top_wall", int'({vga_r, vga_g, vga_b}), 7);
    cycle(320, 0, 1'b0, 1'b1, 1'b1);   settle(); check("blank", int'({vga_r, vga_g, vga_b}), 0);
    cycle(318, 238, 1'b1, 1'b1, 1'b1); settle(); check("ball_px", int'({vga_r, vga_g, vga_b}), 4);
    cycle(20, 240, 1'b1, 1'b1, 1'b1);  settle(); check("paddle_px", int'({vga_r, vga_g, vga_b}), 2);
    cycle(20, 272, 1'b1, 1'b1, 1'b1);  settle(); check("below_paddle", int'({vga_r, vga_g, vga_b}), 0);
    cycle(632, 100, 1'b1, 1'b1, 1'b1); settle(); check("right_wall", int'({vga_r, vga_g, vga_b}), 7);
    cycle(631, 100, 1'b1, 1'b1, 1'b1); settle(); check("left_of_wall", int'({vga_r, vga_g, vga_b}), 0);
    cycle(100, 500, 1'b0, 1'b1, 1'b1); settle();
    cycle(100, 500, 1'b0, 1'b0, 1'b0);
    check("hsync_hold", int'(vga_h_sync), 1);
    settle();
    check("hsync_fall", int'(vga_h_sync), 0);
    check("vsync_fall", int'(vga_v_sync), 0);

    // paddle movement and clamps
    repeat (10) frame(1'b1, 1'b0, 1);
    settle(); check("paddle_up10", int'(o_dbg_paddle_y), 168);
    repeat (50) frame(1'b1, 1'b0, 1);
    settle(); check("paddle_up60", int'(o_dbg_paddle_y), 0);
    repeat (3) frame(1'b0, 1'b1, 1);
    settle(); check("paddle_down3", int'(o_dbg_paddle_y), 12);
    repeat (5) frame(1'b1, 1'b1, 2);
    settle(); check("paddle_both", int'(o_dbg_paddle_y), 12);
    repeat (110) frame(1'b0, 1'b1, 1);
    settle(); check("paddle_down_clamp", int'(o_dbg_paddle_y), 416);

    // reset in the middle of a frame
    do_reset("mid_frame_rst");

    // free ball flight, bottom and right bounces
    repeat (114) frame(1'b0, 1'b0, 1);
    settle();
    check("t114_x", int'(o_dbg_ball_x), 544);
    check("t114_y", int'(o_dbg_ball_y), 464);
    frame(1'b0, 1'b0, 1); settle();
    check("t115_y", int'(o_dbg_ball_y), 464);
    check("t115_up", int'(o_dbg_dir_y), 0);
    frame(1'b0, 1'b0, 1); settle();
    check("t116_y", int'(o_dbg_ball_y), 462);
    repeat (38) frame(1'b0, 1'b0, 1); settle();
    check("t154_x", int'(o_dbg_ball_x), 624);
    check("t154_left", int'(o_dbg_dir_x), 0);
    frame(1'b0, 1'b0, 1); settle();
    check("t155_x", int'(o_dbg_ball_x), 622);

    // reset while the update sequence is running
    btn_up = 1'b1;
    cycle(100, 100, 1'b1, 1'b1, 1'b1);
    cycle(100, 100, 1'b1, 1'b1, 1'b1);
    st_valid = 1'b0;
    cycle(767, 479, 1'b0, 1'b1, 1'b1);
    cycle(700, 490, 1'b0, 1'b1, 1'b1);
    do_reset("mid_update_rst");
    btn_up = 1'b0;

    // paddle parked at the top: ball misses, then miss count saturates
    n_fr = 0;
    ev0 = m_miss_events;
    while (m_miss_events == ev0 && n_fr < 1000) begin
      frame(1'b1, 1'b0, 1);
      n_fr++;
    end
    settle();
    check("miss_frame", n_fr, 467);
    check("miss1_count", int'(miss_count), 1);
    check("miss1_x", int'(o_dbg_ball_x), 316);
    check("miss1_y", int'(o_dbg_ball_y), 236);
    @(negedge clk);
    force dut.w_miss_nxt = 8'hFF;
    @(posedge clk);
    #1;
    release dut.w_miss_nxt;
    m_miss = 255;
    check("miss_forced", int'(miss_count), 255);
    n_fr = 0;
    ev0 = m_miss_events;
    while (m_miss_events == ev0 && n_fr < 1000) begin
      frame(1'b1, 1'b0, 1);
      n_fr++;
    end
    settle();
    check("miss2_frame", n_fr, 467);
    check("miss_saturate", int'(miss_count), 255);

    // randomized play
    do_reset("rand_rst");
    r_up = 1'b0;
    r_dn = 1'b0;
    repeat (1200) begin
      if ($urandom_range(0, 7) == 0) begin
        r_up = rb();
        r_dn = rb();
      end
      frame(r_up, r_dn, int'($urandom_range(1, 3)));
    end
    settle();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
